// File: rtl/alu_pkg.sv
// Shared ALU definitions: add/sub opcode encoding and the status-flag bundle.
package alu_pkg;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_ADC = 2'b10;
  localparam logic [1:0] ALU_SBB = 2'b11;

  typedef struct packed {
    logic carry;
    logic overflow;
    logic zero;
    logic negative;
  } alu_flags_t;

endpackage

// File: rtl/pipelined_cla_addsub_if.sv
// Operand/result handshake bundle for the pipelined adder/subtractor.
interface pipelined_cla_addsub_if #(
  parameter int N = 32
);
  logic         in_valid;
  logic         in_ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic [1:0]   op;
  logic         c_in;
  logic         out_valid;
  logic         out_ready;
  logic [N-1:0] sum;
  logic         carry;
  logic         overflow;
  logic         zero;
  logic         negative;

  modport master (
    output in_valid, a, b, op, c_in, out_ready,
    input  in_ready, out_valid, sum, carry, overflow, zero, negative
  );

  modport slave (
    input  in_valid, a, b, op, c_in, out_ready,
    output in_ready, out_valid, sum, carry, overflow, zero, negative
  );
endinterface

// File: rtl/cla_slice.sv
// Combinational two-level carry-lookahead slice: group P/G, then sum-of-products
// lookahead across groups so no carry ripples from one group into the next.
module cla_slice #(
  parameter int W     = 16,
  parameter int GROUP = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b_eff,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);
  localparam int NG = W / GROUP;

  logic [W-1:0]  w_p;
  logic [W-1:0]  w_g;
  logic [NG-1:0] w_gp;
  logic [NG-1:0] w_gg;
  logic [NG:0]   w_gc;
  logic [W:0]    w_c;

  assign w_p = a ^ b_eff;
  assign w_g = a & b_eff;

  always_comb begin
    logic acc;
    logic prod;
    w_gp = '1;
    w_gg = '0;
    w_gc = '0;
    w_c  = '0;
    for (int g = 0; g < NG; g++) begin
      for (int j = 0; j < GROUP; j++) begin
        w_gg[g] = w_g[g*GROUP+j] | (w_p[g*GROUP+j] & w_gg[g]);
        w_gp[g] = w_gp[g] & w_p[g*GROUP+j];
      end
    end
    // carry into group j expanded directly from all lower group P/G terms
    for (int j = 0; j <= NG; j++) begin
      acc  = 1'b0;
      prod = 1'b1;
      for (int i = j - 1; i >= 0; i--) begin
        acc  = acc | (prod & w_gg[i]);
        prod = prod & w_gp[i];
      end
      w_gc[j] = acc | (prod & cin);
    end
    for (int g = 0; g < NG; g++) begin
      w_c[g*GROUP] = w_gc[g];
      for (int j = 0; j < GROUP - 1; j++) begin
        w_c[g*GROUP+j+1] = w_g[g*GROUP+j] | (w_p[g*GROUP+j] & w_c[g*GROUP+j]);
      end
    end
    w_c[W] = w_gc[NG];
  end

  assign sum   = w_p ^ w_c[W-1:0];
  assign cout  = w_c[W];
  assign c_msb = w_c[W-1];
endmodule

// File: rtl/pipelined_cla_addsub.sv
// Pipelined CLA adder/subtractor: STAGES slices of N/STAGES bits, each followed by a
// register stage carrying finished low sum bits plus the still-unconsumed operand bits.
module pipelined_cla_addsub
  import alu_pkg::*;
#(
  parameter int N      = 32,
  parameter int STAGES = 2,
  parameter int GROUP  = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   clear,
  pipelined_cla_addsub_if.slave  bus
);
  localparam int W = N / STAGES;

  logic [N-1:0]      r_sa [STAGES];
  logic [N-1:0]      r_b  [STAGES];
  logic [STAGES-1:0] r_c;
  logic [STAGES-1:0] r_vld;
  logic              r_cmsb;

  logic [N-1:0]      w_b_eff;
  logic              w_cin0;
  logic              w_accept;
  logic [N-1:0]      w_a_in    [STAGES];
  logic [N-1:0]      w_b_in    [STAGES];
  logic [N-1:0]      w_sa_next [STAGES];
  logic              w_cmsb    [STAGES];
  logic [STAGES-1:0] w_c_in;
  logic [STAGES-1:0] w_cout;
  logic [STAGES-1:0] w_adv;
  logic [STAGES-1:0] w_vld_in;
  alu_flags_t        w_flags;

  always_comb begin
    w_b_eff = bus.b;
    w_cin0  = 1'b0;
    case (bus.op)
      ALU_SUB: begin w_b_eff = ~bus.b; w_cin0 = 1'b1;     end
      ALU_ADC: begin                   w_cin0 = bus.c_in; end
      ALU_SBB: begin w_b_eff = ~bus.b; w_cin0 = bus.c_in; end
      default: ;
    endcase
  end

  genvar gi;
  for (gi = 0; gi < STAGES; gi++) begin : g_stage
    logic [W-1:0] w_sl_sum;
    logic [N-1:0] w_merge;

    if (gi == 0) begin : g_head
      assign w_a_in[gi] = bus.a;
      assign w_b_in[gi] = w_b_eff;
      assign w_c_in[gi] = w_cin0;
    end else begin : g_body
      assign w_a_in[gi] = r_sa[gi-1];
      assign w_b_in[gi] = r_b[gi-1];
      assign w_c_in[gi] = r_c[gi-1];
    end

    cla_slice #(.W(W), .GROUP(GROUP)) u_slice (
      .a     (w_a_in[gi][gi*W +: W]),
      .b_eff (w_b_in[gi][gi*W +: W]),
      .cin   (w_c_in[gi]),
      .sum   (w_sl_sum),
      .cout  (w_cout[gi]),
      .c_msb (w_cmsb[gi])
    );

    // finished sum bits overwrite the operand bits they consumed
    always_comb begin
      w_merge = w_a_in[gi];
      w_merge[gi*W +: W] = w_sl_sum;
    end
    assign w_sa_next[gi] = w_merge;
  end

  // a stage may advance when any stage at or beyond it is empty, or the sink is ready
  always_comb begin
    logic acc;
    acc = bus.out_ready;
    w_adv = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      acc = acc | ~r_vld[k];
      w_adv[k] = acc;
    end
  end

  assign bus.in_ready = w_adv[0] & ~clear;
  assign w_accept     = bus.in_valid & bus.in_ready;

  always_comb begin
    w_vld_in    = '0;
    w_vld_in[0] = w_accept;
    for (int k = 1; k < STAGES; k++) begin
      w_vld_in[k] = r_vld[k-1];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int k = 0; k < STAGES; k++) begin
        r_sa[k] <= '0;
        r_b[k]  <= '0;
      end
      r_c    <= '0;
      r_vld  <= '0;
      r_cmsb <= 1'b0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_adv[k]) begin
          r_sa[k]  <= w_sa_next[k];
          r_b[k]   <= w_b_in[k];
          r_c[k]   <= w_cout[k];
          r_vld[k] <= w_vld_in[k];
        end
      end
      if (w_adv[STAGES-1]) begin
        r_cmsb <= w_cmsb[STAGES-1];
      end
      if (clear) begin
        r_vld <= '0;
      end
    end
  end

  assign w_flags.carry    = r_c[STAGES-1];
  assign w_flags.overflow = r_c[STAGES-1] ^ r_cmsb;
  assign w_flags.zero     = (r_sa[STAGES-1] == '0);
  assign w_flags.negative = r_sa[STAGES-1][N-1];

  assign bus.out_valid = r_vld[STAGES-1];
  assign bus.sum       = r_sa[STAGES-1];
  assign bus.carry     = w_flags.carry;
  assign bus.overflow  = w_flags.overflow;
  assign bus.zero      = w_flags.zero;
  assign bus.negative  = w_flags.negative;
endmodule

// File: tb/tb_pipelined_cla_addsub.sv
// Scoreboard bench for pipelined_cla_addsub (N=32, STAGES=2): driver pushes expected
// results on acceptance, an independent monitor pops and compares on each output transfer.
module tb_pipelined_cla_addsub;
  localparam int N      = 32;
  localparam int STAGES = 2;
  localparam int GROUP  = 4;

  typedef struct {
    logic [31:0] sum;
    logic        c;
    logic        v;
    logic        z;
    logic        n;
    int          acc_cyc;
    bit          chk_lat;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic clear;
  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc   = 0;
  int   n_out = 0;
  bit   rnd_ready = 1'b0;
  exp_t sb[$];

  pipelined_cla_addsub_if #(.N(N)) bus ();

  pipelined_cla_addsub #(.N(N), .STAGES(STAGES), .GROUP(GROUP)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .clear (clear),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic exp_t mk(logic [31:0] s, logic c, logic v, logic z, logic n);
    exp_t e;
    e.sum = s; e.c = c; e.v = v; e.z = z; e.n = n;
    e.acc_cyc = 0; e.chk_lat = 1'b0;
    return e;
  endfunction

  // reference: plain 33-bit unsigned and 64-bit signed arithmetic
  function automatic exp_t model(logic [31:0] a, logic [31:0] b, logic [1:0] op, logic cin);
    logic [31:0] bb;
    logic        ci;
    logic [32:0] u;
    longint      s;
    case (op)
      2'b00:   begin bb = b;  ci = 1'b0; end
      2'b01:   begin bb = ~b; ci = 1'b1; end
      2'b10:   begin bb = b;  ci = cin;  end
      default: begin bb = ~b; ci = cin;  end
    endcase
    u = {1'b0, a} + {1'b0, bb} + {32'b0, ci};
    s = longint'($signed(a)) + longint'($signed(bb)) + longint'(ci);
    return mk(u[31:0], u[32], (s > 64'sd2147483647) || (s < -64'sd2147483648),
              u[31:0] == 32'h0, u[31]);
  endfunction

  task automatic drive_op(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op,
                          input logic cin, input bit use_dir, input exp_t dir, input bit chk_lat);
    exp_t e;
    int   t;
    bus.in_valid = 1'b1; bus.a = a; bus.b = b; bus.op = op; bus.c_in = cin;
    t = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      t++;
      if (t > 500) begin
        n_cmp++; n_err++;
        $display("FAIL accept_timeout: in_ready stayed 0, required 1 within 500 cycles");
        bus.in_valid = 1'b0;
        return;
      end
      @(posedge clk); #1;
    end
    e = use_dir ? dir : model(a, b, op, cin);
    e.acc_cyc = cyc;
    e.chk_lat = chk_lat;
    sb.push_back(e);
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(posedge clk);
      t++;
    end
    n_cmp++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL drain_timeout: %0d results pending, required 0", sb.size());
    end
    @(posedge clk); #1;
  endtask

  // monitor: compare on every transfer; check stability while stalled
  initial begin
    logic [35:0] held;
    bit          hold_valid;
    exp_t        e;
    hold_valid = 1'b0;
    held = '0;
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.out_valid === 1'b1) begin
        if (bus.out_ready === 1'b1) begin
          hold_valid = 1'b0;
          n_cmp++;
          if (sb.size() == 0) begin
            n_err++;
            $display("FAIL unexpected_output: sum=0x%08h with no pending result, required none", bus.sum);
          end else begin
            e = sb.pop_front();
            n_out++;
            $display("out %0d: sum=%08h c=%b v=%b z=%b n=%b", n_out, bus.sum,
                     bus.carry, bus.overflow, bus.zero, bus.negative);
            check("sum", bus.sum, e.sum);
            check("carry", bus.carry, e.c);
            check("overflow", bus.overflow, e.v);
            check("zero", bus.zero, e.z);
            check("negative", bus.negative, e.n);
            if (e.chk_lat) check("latency", cyc - e.acc_cyc, STAGES);
          end
        end else begin
          if (hold_valid)
            check("stall_stable", {bus.sum, bus.carry, bus.overflow, bus.zero, bus.negative}, held);
          held = {bus.sum, bus.carry, bus.overflow, bus.zero, bus.negative};
          hold_valid = 1'b1;
        end
      end else begin
        hold_valid = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rnd_ready) bus.out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t none;
    int   acc;
    logic last_rdy;
    none = mk(32'h0, 1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b0; clear = 1'b0;
    bus.in_valid = 1'b0; bus.a = '0; bus.b = '0; bus.op = 2'b00; bus.c_in = 1'b0;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 1'b0);
    check("rst_sum", bus.sum, 32'h0);
    check("rst_carry", bus.carry, 1'b0);
    check("rst_overflow", bus.overflow, 1'b0);
    check("rst_zero", bus.zero, 1'b1);
    check("rst_negative", bus.negative, 1'b0);
    check("rst_in_ready", bus.in_ready, 1'b1);
    @(posedge clk); #1;

    // directed vectors, back to back
    drive_op(32'h7FFFFFFF, 32'h00000001, 2'b00, 1'b0, 1, mk(32'h80000000, 0, 1, 0, 1), 1);
    drive_op(32'h00000005, 32'h00000005, 2'b01, 1'b0, 1, mk(32'h00000000, 1, 0, 1, 0), 1);
    drive_op(32'h00000000, 32'h00000001, 2'b01, 1'b0, 1, mk(32'hFFFFFFFF, 0, 0, 0, 1), 1);
    drive_op(32'hFFFFFFFF, 32'h00000001, 2'b00, 1'b0, 1, mk(32'h00000000, 1, 0, 1, 0), 1);
    drive_op(32'h00000000, 32'h00000000, 2'b10, 1'b1, 1, mk(32'h00000001, 0, 0, 0, 0), 1);
    drive_op(32'h00000000, 32'h00000000, 2'b11, 1'b0, 1, mk(32'hFFFFFFFF, 0, 0, 0, 1), 1);
    drain();

    // 8 random ops on consecutive cycles
    for (int i = 0; i < 8; i++)
      drive_op($urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0, none, 1);
    drain();

    // random traffic with random backpressure and gaps
    rnd_ready = 1'b1;
    for (int i = 0; i < 150; i++) begin
      drive_op($urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0, none, 0);
      repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    end
    rnd_ready = 1'b0;
    bus.out_ready = 1'b1;
    drain();

    // backpressure: 5 cycles of offered input with the sink stalled
    bus.out_ready = 1'b0;
    acc = 0;
    last_rdy = 1'b1;
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1; bus.a = $urandom; bus.b = $urandom;
      bus.op = 2'($urandom_range(0, 3)); bus.c_in = 1'($urandom_range(0, 1));
      @(negedge clk);
      last_rdy = bus.in_ready;
      if (bus.in_ready) begin
        sb.push_back(model(bus.a, bus.b, bus.op, bus.c_in));
        acc++;
      end
      @(posedge clk); #1;
    end
    check("bp_accepts", acc, STAGES);
    check("bp_in_ready", last_rdy, 1'b0);

    // clear with in_valid high: nothing accepted, pipeline empties
    clear = 1'b1; bus.out_ready = 1'b1; bus.in_valid = 1'b1;
    @(negedge clk);
    check("clear_in_ready", bus.in_ready, 1'b0);
    @(posedge clk); #1;
    clear = 1'b0; bus.in_valid = 1'b0;
    check("clear_out_valid", bus.out_valid, 1'b0);
    sb.delete();
    @(negedge clk);
    check("clear_out_valid_1", bus.out_valid, 1'b0);
    @(posedge clk); #1;
    @(negedge clk);
    check("clear_out_valid_2", bus.out_valid, 1'b0);
    @(posedge clk); #1;

    // reset with two ops in flight
    bus.out_ready = 1'b0;
    drive_op($urandom, $urandom, 2'b00, 1'b0, 0, none, 0);
    drive_op($urandom, $urandom, 2'b01, 1'b0, 0, none, 0);
    check("inflight_out_valid", bus.out_valid, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_out_valid", bus.out_valid, 1'b0);
    check("midrst_sum", bus.sum, 32'h0);
    sb.delete();
    @(posedge clk); #1;
    rst_n = 1'b1;
    bus.out_ready = 1'b1;
    drive_op(32'h12345678, 32'h11111111, 2'b00, 1'b0, 1, mk(32'h23456789, 0, 0, 0, 0), 1);
    for (int i = 0; i < 4; i++)
      drive_op($urandom, $urandom, 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 0, none, 1);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
